// File: rtl/sbit_gate_monitor.sv
// -----------------------------------------------------------------------------
// sbit_gate_monitor
//
// Sits between the per-VFAT frame aligner and the cluster finder. S-bits are
// forwarded only once the link is aligned and has settled for a programmable
// number of cycles. They are blanked on loss of alignment or masking. Each
// 8-bit group that stays nonzero for too long is flagged as stuck and zeroed.
// Exits from the forwarding state are counted for slow control.
//
// Optional feature macro: SBIT_GATE_RATE_EN
//   When defined, adds rate_window_i / rate_o. rate_o reports how many ACTIVE
//   cycles within each window produced a nonzero sbits_o.
//
// Ports:
//   clock             in   40 MHz frame clock
//   reset_i           in   synchronous active-high reset
//   sbits_i           in   aligned S-bits from the frame aligner
//   sot_is_aligned_i  in   aligner ready flag
//   sot_unstable_i    in   aligner sticky unstable flag
//   mask_i            in   VFAT masked by slow control
//   holdoff_i         in   settle cycles after alignment before forwarding
//   stuck_limit_i     in   consecutive nonzero BX that declare a group stuck
//                          (0 disables detection)
//   stuck_clear_i     in   pulse: clear stuck flags and counters
//   rate_window_i     in   (SBIT_GATE_RATE_EN) rate window length in cycles
//   rate_o            out  (SBIT_GATE_RATE_EN) latched rate count
//   sbits_o           out  gated S-bits, one cycle of latency
//   active_o          out  high while in ACTIVE
//   state_o           out  0=WAIT_ALIGN, 1=SETTLE, 2=ACTIVE
//   stuck_mask_o      out  sticky per-group stuck flags
//   realign_cnt_o     out  saturating count of ACTIVE exits
// -----------------------------------------------------------------------------
module sbit_gate_monitor #(
    parameter int MXSBITS          = 64,
    parameter int NGROUPS          = MXSBITS / 8,
    parameter int REALIGN_CNT_BITS = 16
) (
    input  logic                        clock,
    input  logic                        reset_i,
    input  logic [MXSBITS-1:0]          sbits_i,
    input  logic                        sot_is_aligned_i,
    input  logic                        sot_unstable_i,
    input  logic                        mask_i,
    input  logic [7:0]                  holdoff_i,
    input  logic [7:0]                  stuck_limit_i,
    input  logic                        stuck_clear_i,
`ifdef SBIT_GATE_RATE_EN
    input  logic [23:0]                 rate_window_i,
    output logic [23:0]                 rate_o,
`endif
    output logic [MXSBITS-1:0]          sbits_o,
    output logic                        active_o,
    output logic [1:0]                  state_o,
    output logic [NGROUPS-1:0]          stuck_mask_o,
    output logic [REALIGN_CNT_BITS-1:0] realign_cnt_o
);

    typedef enum logic [1:0] {
        ST_WAIT_ALIGN = 2'd0,
        ST_SETTLE     = 2'd1,
        ST_ACTIVE     = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_next_state;
    logic [7:0]                    r_holdoff;
    logic [7:0]                    w_next_holdoff;
    logic                          w_realign_exit;
    logic                          w_bad;
    logic [REALIGN_CNT_BITS-1:0]   r_realign_cnt;
    logic [MXSBITS-1:0]            r_sbits;
    logic [MXSBITS-1:0]            w_stuck_bits;
    logic [NGROUPS-1:0]            r_stuck_mask;
    logic [7:0]                    r_stuck_cnt [NGROUPS];
    logic [8:0]                    w_cnt_inc   [NGROUPS];
    logic [NGROUPS-1:0]            w_grp_hit;

    assign w_bad = mask_i | ~sot_is_aligned_i | sot_unstable_i;

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (reset_i) begin
            r_state       <= ST_WAIT_ALIGN;
            r_holdoff     <= 8'd0;
            r_realign_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_holdoff <= w_next_holdoff;
            // Saturate rather than wrap so slow control never sees a false low count.
            if (w_realign_exit && (r_realign_cnt != {REALIGN_CNT_BITS{1'b1}}))
                r_realign_cnt <= r_realign_cnt + REALIGN_CNT_BITS'(1);
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_holdoff = r_holdoff;
        w_realign_exit = 1'b0;
        case (r_state)
            ST_WAIT_ALIGN: begin
                if (!w_bad) begin
                    w_next_state   = ST_SETTLE;
                    w_next_holdoff = holdoff_i;
                end
            end
            ST_SETTLE: begin
                // The counter reaches zero after holdoff_i decrements, so the
                // link spends holdoff_i+1 cycles here before forwarding.
                if (w_bad)
                    w_next_state = ST_WAIT_ALIGN;
                else if (r_holdoff == 8'd0)
                    w_next_state = ST_ACTIVE;
                else
                    w_next_holdoff = r_holdoff - 8'd1;
            end
            ST_ACTIVE: begin
                if (w_bad) begin
                    w_next_state   = ST_WAIT_ALIGN;
                    w_realign_exit = 1'b1;
                end
            end
            default: w_next_state = ST_WAIT_ALIGN;
        endcase
    end

    // ---------------- stuck detection ----------------
    always_comb begin
        w_grp_hit    = '0;
        w_stuck_bits = '0;
        for (int g = 0; g < NGROUPS; g++) begin
            w_grp_hit[g]           = (r_state == ST_ACTIVE) && (stuck_limit_i != 8'd0) &&
                                     (sbits_i[8*g +: 8] != 8'd0);
            w_cnt_inc[g]           = {1'b0, r_stuck_cnt[g]} + 9'd1;
            w_stuck_bits[8*g +: 8] = {8{r_stuck_mask[g]}};
        end
    end

    always_ff @(posedge clock) begin
        if (reset_i) begin
            r_stuck_mask <= '0;
            for (int g = 0; g < NGROUPS; g++)
                r_stuck_cnt[g] <= 8'd0;
        end else begin
            for (int g = 0; g < NGROUPS; g++) begin
                // Clear has priority over a flag that would set this cycle.
                if (stuck_clear_i) begin
                    r_stuck_cnt[g]  <= 8'd0;
                    r_stuck_mask[g] <= 1'b0;
                end else if (w_grp_hit[g]) begin
                    if (r_stuck_cnt[g] != 8'hFF)
                        r_stuck_cnt[g] <= w_cnt_inc[g][7:0];
                    // Compare the post-increment count so the flag lands on the
                    // edge that ends the Nth nonzero cycle.
                    if (w_cnt_inc[g] >= {1'b0, stuck_limit_i})
                        r_stuck_mask[g] <= 1'b1;
                end else begin
                    r_stuck_cnt[g] <= 8'd0;
                end
            end
        end
    end

    // ---------------- data path ----------------
    // Gate on the current state, so the first bad cycle of an ACTIVE exit
    // still forwards its S-bits.
    always_ff @(posedge clock) begin
        if (reset_i)
            r_sbits <= '0;
        else if (r_state == ST_ACTIVE)
            r_sbits <= sbits_i & ~w_stuck_bits;
        else
            r_sbits <= '0;
    end

`ifdef SBIT_GATE_RATE_EN
    logic [23:0] r_win_cnt;
    logic [23:0] r_rate_cnt;
    logic [23:0] r_rate;
    logic        w_rate_hit;
    logic [23:0] w_rate_sum;

    assign w_rate_hit = (r_state == ST_ACTIVE) && (r_sbits != '0);
    assign w_rate_sum = (w_rate_hit && (r_rate_cnt != 24'hFFFFFF)) ? r_rate_cnt + 24'd1
                                                                   : r_rate_cnt;

    always_ff @(posedge clock) begin
        if (reset_i) begin
            r_win_cnt  <= 24'd0;
            r_rate_cnt <= 24'd0;
            r_rate     <= 24'd0;
        end else if (rate_window_i != 24'd0) begin
            // >= keeps the window sane if it is shortened mid-count.
            if (r_win_cnt >= rate_window_i - 24'd1) begin
                r_rate     <= w_rate_sum;
                r_win_cnt  <= 24'd0;
                r_rate_cnt <= 24'd0;
            end else begin
                r_win_cnt  <= r_win_cnt + 24'd1;
                r_rate_cnt <= w_rate_sum;
            end
        end
    end

    assign rate_o = r_rate;
`endif

    assign sbits_o       = r_sbits;
    assign active_o      = (r_state == ST_ACTIVE);
    assign state_o       = r_state;
    assign stuck_mask_o  = r_stuck_mask;
    assign realign_cnt_o = r_realign_cnt;

endmodule

// File: tb/tb_sbit_gate_monitor.sv
// -----------------------------------------------------------------------------
// tb_sbit_gate_monitor
//
// Directed bench for sbit_gate_monitor (default build, rate feature off).
// A second instance with a 3-bit realignment counter makes the saturation
// behaviour reachable in a few dozen cycles.
// Expected outputs come from a behavioural model of the gating rules; a few
// hand-computed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_sbit_gate_monitor;

    localparam int MXS = 64;
    localparam int NG  = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_i;
    logic [MXS-1:0] sbits_i;
    logic           sot_is_aligned_i;
    logic           sot_unstable_i;
    logic           mask_i;
    logic [7:0]     holdoff_i;
    logic [7:0]     stuck_limit_i;
    logic           stuck_clear_i;

    logic [MXS-1:0] sbits_o;
    logic           active_o;
    logic [1:0]     state_o;
    logic [NG-1:0]  stuck_mask_o;
    logic [15:0]    realign_cnt_o;

    logic [MXS-1:0] sbits_n;
    logic           active_n;
    logic [1:0]     state_n;
    logic [NG-1:0]  stuck_n;
    logic [2:0]     realign_n;

    sbit_gate_monitor u_dut (
        .clock            (clk),
        .reset_i          (reset_i),
        .sbits_i          (sbits_i),
        .sot_is_aligned_i (sot_is_aligned_i),
        .sot_unstable_i   (sot_unstable_i),
        .mask_i           (mask_i),
        .holdoff_i        (holdoff_i),
        .stuck_limit_i    (stuck_limit_i),
        .stuck_clear_i    (stuck_clear_i),
        .sbits_o          (sbits_o),
        .active_o         (active_o),
        .state_o          (state_o),
        .stuck_mask_o     (stuck_mask_o),
        .realign_cnt_o    (realign_cnt_o)
    );

    sbit_gate_monitor #(.REALIGN_CNT_BITS(3)) u_dut_narrow (
        .clock            (clk),
        .reset_i          (reset_i),
        .sbits_i          (sbits_i),
        .sot_is_aligned_i (sot_is_aligned_i),
        .sot_unstable_i   (sot_unstable_i),
        .mask_i           (mask_i),
        .holdoff_i        (holdoff_i),
        .stuck_limit_i    (stuck_limit_i),
        .stuck_clear_i    (stuck_clear_i),
        .sbits_o          (sbits_n),
        .active_o         (active_n),
        .state_o          (state_n),
        .stuck_mask_o     (stuck_n),
        .realign_cnt_o    (realign_n)
    );

    // ---------------- checking helpers ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [MXS-1:0] expand(input logic [NG-1:0] f);
        logic [MXS-1:0] r;
        r = '0;
        for (int g = 0; g < NG; g++)
            if (f[g]) r[8*g +: 8] = 8'hFF;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    // Phase follows the published state_o numbering. Settling is tracked as
    // "cycles spent settling" against a target of holdoff+1 cycles.
    int             m_phase   = 0;
    int             m_settled = 0;
    int             m_target  = 0;
    int             m_exits   = 0;
    int             m_run [NG];
    logic [NG-1:0]  m_flags   = '0;
    logic           m_bad;
    logic [MXS-1:0] exp_q [$];

    assign m_bad = mask_i | ~sot_is_aligned_i | sot_unstable_i;

    initial for (int g = 0; g < NG; g++) m_run[g] = 0;

    always @(posedge clk) begin
        if (reset_i) begin
            m_phase   <= 0;
            m_settled <= 0;
            m_target  <= 0;
            m_exits   <= 0;
            m_flags   <= '0;
            for (int g = 0; g < NG; g++) m_run[g] <= 0;
            exp_q.push_back('0);
        end else begin
            exp_q.push_back((m_phase == 2) ? (sbits_i & ~expand(m_flags)) : '0);
            if (m_phase == 0) begin
                if (!m_bad) begin
                    m_phase   <= 1;
                    m_settled <= 0;
                    m_target  <= int'(holdoff_i) + 1;
                end
            end else if (m_phase == 1) begin
                if (m_bad)
                    m_phase <= 0;
                else if (m_settled + 1 == m_target)
                    m_phase <= 2;
                else
                    m_settled <= m_settled + 1;
            end else begin
                if (m_bad) begin
                    m_phase <= 0;
                    m_exits <= m_exits + 1;
                end
            end
            for (int g = 0; g < NG; g++) begin
                if (stuck_clear_i) begin
                    m_run[g]   <= 0;
                    m_flags[g] <= 1'b0;
                end else if (m_phase == 2 && stuck_limit_i != 8'd0 && sbits_i[8*g +: 8] != 8'd0) begin
                    m_run[g] <= m_run[g] + 1;
                    if (m_run[g] + 1 >= int'(stuck_limit_i)) m_flags[g] <= 1'b1;
                end else begin
                    m_run[g] <= 0;
                end
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [MXS-1:0] exp_sb;

    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            check_val("exp_q_empty", 64'd0, 64'd1);
        end else begin
            exp_sb = exp_q.pop_front();
            check_val("sbits_o", sbits_o, exp_sb);
            check_val("sbits_narrow", sbits_n, exp_sb);
        end
        check_val("state_o", {62'd0, state_o}, 64'(m_phase));
        check_val("active_o", {63'd0, active_o}, {63'd0, (m_phase == 2)});
        check_val("stuck_mask_o", {56'd0, stuck_mask_o}, {56'd0, m_flags});
        check_val("realign_cnt_o", {48'd0, realign_cnt_o}, 64'((m_exits > 65535) ? 65535 : m_exits));
        check_val("realign_narrow", {61'd0, realign_n}, 64'((m_exits > 7) ? 7 : m_exits));
        check_val("state_narrow", {62'd0, state_n}, 64'(m_phase));
        check_val("active_narrow", {63'd0, active_n}, {63'd0, (m_phase == 2)});
        check_val("stuck_narrow", {56'd0, stuck_n}, {56'd0, m_flags});
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_val(name, act, exp);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset_i          = 1'b1;
        sbits_i          = 64'h1;
        sot_is_aligned_i = 1'b1;
        sot_unstable_i   = 1'b0;
        mask_i           = 1'b0;
        holdoff_i        = 8'd3;
        stuck_limit_i    = 8'd0;
        stuck_clear_i    = 1'b0;

        // Startup
        tick(4);
        lit("rst_state", {62'd0, state_o}, 64'd0);
        lit("rst_sbits", sbits_o, 64'd0);
        lit("rst_realign", {48'd0, realign_cnt_o}, 64'd0);
        lit("rst_stuck", {56'd0, stuck_mask_o}, 64'd0);
        reset_i = 1'b0;
        tick(1);
        lit("start_settle", {62'd0, state_o}, 64'd1);
        tick(3);
        lit("start_still_settle", {62'd0, state_o}, 64'd1);
        lit("start_sbits_blank", sbits_o, 64'd0);
        tick(1);
        lit("start_active", {62'd0, state_o}, 64'd2);
        lit("start_active_o", {63'd0, active_o}, 64'd1);
        lit("start_first_active_sbits", sbits_o, 64'd0);
        tick(1);
        lit("start_fwd", sbits_o, 64'h1);

        // Alignment loss for one cycle
        sot_is_aligned_i = 1'b0;
        tick(1);
        lit("loss_wait", {62'd0, state_o}, 64'd0);
        lit("loss_realign", {48'd0, realign_cnt_o}, 64'd1);
        lit("loss_bad_cycle_passes", sbits_o, 64'h1);
        sot_is_aligned_i = 1'b1;
        tick(1);
        lit("loss_resettle", {62'd0, state_o}, 64'd1);
        lit("loss_blank", sbits_o, 64'd0);
        tick(3);
        lit("loss_holdoff_reloaded", {62'd0, state_o}, 64'd1);
        tick(1);
        lit("loss_reactive", {62'd0, state_o}, 64'd2);

        // Mask during SETTLE
        sot_is_aligned_i = 1'b0;
        tick(1);
        lit("mask_pre_realign", {48'd0, realign_cnt_o}, 64'd2);
        holdoff_i        = 8'd10;
        sot_is_aligned_i = 1'b1;
        tick(4);
        lit("mask_settling", {62'd0, state_o}, 64'd1);
        mask_i = 1'b1;
        tick(1);
        lit("mask_wait", {62'd0, state_o}, 64'd0);
        lit("mask_realign_same", {48'd0, realign_cnt_o}, 64'd2);
        lit("mask_blank", sbits_o, 64'd0);
        mask_i = 1'b0;
        tick(11);
        lit("mask_long_settle", {62'd0, state_o}, 64'd1);
        tick(1);
        lit("mask_active", {62'd0, state_o}, 64'd2);

        // Unstable flag exit, then a single SETTLE cycle with holdoff 0
        sot_unstable_i = 1'b1;
        tick(1);
        lit("unstable_wait", {62'd0, state_o}, 64'd0);
        lit("unstable_realign", {48'd0, realign_cnt_o}, 64'd3);
        sot_unstable_i = 1'b0;
        holdoff_i      = 8'd0;
        tick(1);
        lit("h0_settle", {62'd0, state_o}, 64'd1);
        tick(1);
        lit("h0_active", {62'd0, state_o}, 64'd2);

        // Stuck group: four cycles then a gap does not flag; five does
        stuck_limit_i = 8'd5;
        sbits_i       = 64'hFF00;
        tick(4);
        lit("stuck_4_no_flag", {56'd0, stuck_mask_o}, 64'd0);
        sbits_i = 64'h0;
        tick(1);
        sbits_i = 64'hFF00;
        tick(4);
        lit("stuck_4b_no_flag", {56'd0, stuck_mask_o}, 64'd0);
        tick(1);
        lit("stuck_flag", {56'd0, stuck_mask_o}, 64'h02);
        lit("stuck_last_unmasked", sbits_o, 64'hFF00);
        sbits_i = 64'hFF01;
        tick(1);
        lit("stuck_masked_bit0_passes", sbits_o, 64'h1);
        for (int i = 0; i < 6; i++) begin
            sbits_i = 64'hFF00 | 64'(i % 2);
            tick(1);
        end
        lit("stuck_sticky", {56'd0, stuck_mask_o}, 64'h02);

        // Clear priority over a same-cycle set
        stuck_clear_i = 1'b1;
        sbits_i       = 64'hFF00;
        tick(1);
        lit("clear_flag", {56'd0, stuck_mask_o}, 64'd0);
        stuck_clear_i = 1'b0;
        tick(4);
        stuck_clear_i = 1'b1;
        tick(1);
        lit("clear_wins", {56'd0, stuck_mask_o}, 64'd0);
        stuck_clear_i = 1'b0;
        tick(4);
        lit("clear_recount_4", {56'd0, stuck_mask_o}, 64'd0);
        tick(1);
        lit("clear_recount_5", {56'd0, stuck_mask_o}, 64'h02);

        // Limit change takes effect against the running count
        stuck_clear_i = 1'b1;
        tick(1);
        stuck_clear_i = 1'b0;
        stuck_limit_i = 8'd20;
        tick(6);
        lit("limit20_no_flag", {56'd0, stuck_mask_o}, 64'd0);
        stuck_limit_i = 8'd3;
        tick(1);
        lit("limit_drop_flags", {56'd0, stuck_mask_o}, 64'h02);

        // Limit 0 disables detection
        stuck_clear_i = 1'b1;
        tick(1);
        stuck_clear_i = 1'b0;
        stuck_limit_i = 8'd0;
        tick(8);
        lit("limit0_no_flag", {56'd0, stuck_mask_o}, 64'd0);
        lit("limit0_passes", sbits_o, 64'hFF00);

        // Flags survive a realignment
        stuck_limit_i = 8'd2;
        tick(2);
        lit("sticky_set", {56'd0, stuck_mask_o}, 64'h02);
        sot_is_aligned_i = 1'b0;
        tick(1);
        lit("sticky_realign", {48'd0, realign_cnt_o}, 64'd4);
        sot_is_aligned_i = 1'b1;
        tick(2);
        lit("sticky_after_realign", {56'd0, stuck_mask_o}, 64'h02);
        stuck_clear_i = 1'b1;
        tick(1);
        stuck_clear_i = 1'b0;
        stuck_limit_i = 8'd0;

        // Saturation on the narrow instance
        for (int i = 0; i < 5; i++) begin
            sot_is_aligned_i = 1'b0;
            tick(1);
            sot_is_aligned_i = 1'b1;
            tick(2);
        end
        lit("sat_wide", {48'd0, realign_cnt_o}, 64'd9);
        lit("sat_narrow", {61'd0, realign_n}, 64'd7);
        lit("sat_active", {62'd0, state_o}, 64'd2);

        // Reset mid-operation
        reset_i = 1'b1;
        tick(1);
        lit("midrst_state", {62'd0, state_o}, 64'd0);
        lit("midrst_realign", {48'd0, realign_cnt_o}, 64'd0);
        lit("midrst_sbits", sbits_o, 64'd0);
        reset_i = 1'b0;
        tick(2);
        lit("midrst_reactive", {62'd0, state_o}, 64'd2);
        lit("midrst_no_count", {48'd0, realign_cnt_o}, 64'd0);

        sbits_i = 64'h0;
        tick(2);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
